// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a DEPTH-entry byte FIFO.
// Frames are sent back to back while the FIFO holds data. Bit timing
// comes from a cycle counter on the system clock.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 1252,
   parameter int DEPTH        = 32,
   parameter int CNT_W        = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [BAUD_W-1:0] baud;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              wr_accept;
   logic              pop;
   logic              baud_last;
   logic              bit_adv;
   logic [CNT_W-1:0]  count_next;

   // Write acceptance, pop decision and next occupancy.
   always_comb begin
      wr_accept  = wr_en && !full;
      baud_last  = (baud == BAUD_LAST);
      pop        = !empty && ((state == IDLE) || ((state == STOP) && baud_last));
      bit_adv    = (state == DATA) && baud_last && (bit_idx != 3'd7);
      count_next = count;
      if (wr_accept && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (!wr_accept && pop) begin
         count_next = count - CNT_W'(1);
      end
   end

   // FIFO storage; data only, no reset needed.
   always_ff @(posedge clock) begin
      if (wr_accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and flags; a rejected write only raises overflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
         full  <= (count_next == CNT_FULL);
         empty <= (count_next == '0);
      end
   end

   // Shift register: loaded on pop, shifted right on each data-bit advance.
   always_ff @(posedge clock) begin
      if (pop) begin
         shift <= mem[rd_ptr];
      end else if (bit_adv) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   // Frame sequencer with registered tx/busy/tx_done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               baud <= '0;
               if (pop) begin
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (baud_last) begin
                  state   <= DATA;
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end
            STOP: begin
               // tx_done is registered, so raise it one cycle early to land on the last stop cycle.
               if (baud == BAUD_PRE) begin
                  tx_done <= 1'b1;
               end
               if (baud_last) begin
                  baud <= '0;
                  if (pop) begin
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table-driven single frames plus scoreboarded
// bursts, overflow, wrap-around, same-edge write/pop and mid-frame reset.
module tb_uart_tx_fifo;

   localparam int CPB      = 4;
   localparam int SLOW_CPB = 1252;

   logic       clock = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, overflow, tx, busy, tx_done;
   logic [5:0] count;

   logic       s_wr_en;
   logic [7:0] s_wr_data;
   logic       s_full, s_empty, s_overflow, s_tx, s_busy, s_tx_done;
   logic [5:0] s_count;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int max_cnt = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;
   vec_t vecs [4];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(32), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(SLOW_CPB), .DEPTH(32), .CNT_W(6)) dut_slow (
      .clock(clock), .reset(reset), .wr_en(s_wr_en), .wr_data(s_wr_data),
      .full(s_full), .empty(s_empty), .count(s_count), .overflow(s_overflow),
      .tx(s_tx), .busy(s_busy), .tx_done(s_tx_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (tx_done) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
      if (int'(count) > max_cnt) max_cnt <= int'(count);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) exp_q.push_back(d);
      @(posedge clock);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [9:0] frame, input string tag);
      logic [39:0] cap_tx, cap_done, exp_tx;
      write_byte(d, 1'b0);
      check({tag, "_empty_k"}, empty, 1'b0);
      check({tag, "_count_k"}, count, 6'd1);
      tick();
      check({tag, "_busy_k1"}, busy, 1'b1);
      check({tag, "_count_k1"}, count, 6'd0);
      for (int i = 0; i < 40; i++) begin
         cap_tx[i]   = tx;
         cap_done[i] = tx_done;
         exp_tx[i]   = frame[i / CPB];
         tick();
      end
      check({tag, "_tx_bits"}, cap_tx, exp_tx);
      check({tag, "_tx_done"}, cap_done, 40'h80_0000_0000);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_tx_end"}, tx, 1'b1);
      check({tag, "_count_end"}, count, 6'd0);
   endtask

   task automatic decode_frames(input int n, input bit check_gap, output int first_start);
      int prev, waited, start_c;
      bit got;
      logic [7:0] rx;
      logic [7:0] want;
      prev = 0;
      first_start = -1;
      for (int f = 0; f < n; f++) begin
         waited = 0;
         got = 1'b0;
         while (!got && waited < 400) begin
            @(negedge clock);
            waited++;
            if (tx === 1'b0) got = 1'b1;
         end
         if (!got) begin
            n_total++;
            $display("FAIL dec_timeout: frame %0d start bit not seen within 400 cycles", f);
            return;
         end
         start_c = cyc;
         if (f == 0) first_start = start_c;
         if (check_gap && f > 0) check("frame_period", 64'(start_c - prev), 64'(10 * CPB));
         prev = start_c;
         repeat (CPB / 2) @(negedge clock);
         check("start_bit", tx, 1'b0);
         for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clock);
            rx[b] = tx;
         end
         repeat (CPB) @(negedge clock);
         check("stop_bit", tx, 1'b1);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL rx_unexpected: got 0x%0h expected no frame", rx);
         end else begin
            want = exp_q.pop_front();
            check("rx_byte", rx, want);
         end
      end
   endtask

   initial begin
      int fs, base;
      vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
      vecs[1] = '{8'h3C, 10'b1_0011_1100_0};
      vecs[2] = '{8'h01, 10'b1_0000_0001_0};
      vecs[3] = '{8'h80, 10'b1_1000_0000_0};

      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      s_wr_en = 1'b0; s_wr_data = 8'h00;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_count", count, 6'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_tx_done", tx_done, 1'b0);
      reset = 1'b0;
      tick();
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);

      // single frames from the vector table
      for (int v = 0; v < 4; v++) begin
         run_frame(vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));
      end

      // burst of three bytes on consecutive edges
      base = done_cnt;
      fork
         begin
            write_byte(8'h00, 1'b1); check("burst_count0", count, 6'd1);
            write_byte(8'hFF, 1'b1); check("burst_count1", count, 6'd1);
            write_byte(8'h55, 1'b1); check("burst_count2", count, 6'd2);
         end
         decode_frames(3, 1'b1, fs);
      join
      repeat (4) tick();
      check("burst_done_pulses", 64'(done_cnt - base), 64'd3);
      check("burst_total_len", 64'(last_done_cyc - fs), 64'd119);
      check("burst_busy_end", busy, 1'b0);

      // fill while a frame is stalled mid-line, then overflow
      fork
         begin
            for (int i = 0; i < 33; i++) write_byte(8'(i * 7 + 3), 1'b1);
            check("fill_full", full, 1'b1);
            check("fill_count", count, 6'd32);
            write_byte(8'hEE, 1'b0);
            check("ovf_pulse", overflow, 1'b1);
            check("ovf_count", count, 6'd32);
            check("ovf_full", full, 1'b1);
            tick();
            check("ovf_clear", overflow, 1'b0);
         end
         decode_frames(33, 1'b1, fs);
      join
      repeat (4) tick();
      check("fill_q_drained", 64'(exp_q.size()), 64'd0);
      check("fill_empty_end", empty, 1'b1);

      // same fill on the full-rate-divider instance
      for (int i = 0; i < 34; i++) begin
         s_wr_en = 1'b1;
         s_wr_data = 8'(i + 1);
         tick();
         s_wr_en = 1'b0;
         if (i == 32) begin
            check("slow_full", s_full, 1'b1);
            check("slow_count", s_count, 6'd32);
            check("slow_empty", s_empty, 1'b0);
         end
         if (i == 33) begin
            check("slow_overflow", s_overflow, 1'b1);
            check("slow_count_ovf", s_count, 6'd32);
            check("slow_busy", s_busy, 1'b1);
            check("slow_tx_start", s_tx, 1'b0);
            check("slow_tx_done", s_tx_done, 1'b0);
         end
      end

      // wrap-around stream of 70 incrementing bytes
      fork
         begin
            for (int i = 0; i < 70; i++) begin
               write_byte(8'(i + 8'h40), 1'b1);
               if (i >= 5) repeat (39) tick();
            end
         end
         decode_frames(70, 1'b1, fs);
      join
      repeat (4) tick();
      check("wrap_q_drained", 64'(exp_q.size()), 64'd0);
      check("wrap_max_count", 64'(max_cnt <= 32), 64'd1);

      // write and pop on the same edge at the end of a stop bit
      fork
         begin
            for (int i = 0; i < 6; i++) write_byte(8'(8'hB0 + i), 1'b1);
            check("sim_count_pre", count, 6'd5);
            repeat (35) tick();
            check("sim_count_last", count, 6'd5);
            check("sim_tx_stop", tx, 1'b1);
            check("sim_tx_done", tx_done, 1'b1);
            write_byte(8'hC7, 1'b1);
            check("sim_count_post", count, 6'd5);
            check("sim_tx_start", tx, 1'b0);
            check("sim_busy", busy, 1'b1);
         end
         decode_frames(7, 1'b1, fs);
      join
      repeat (4) tick();
      check("sim_q_drained", 64'(exp_q.size()), 64'd0);

      // reset during data bit 3
      write_byte(8'h52, 1'b0);
      write_byte(8'h11, 1'b0);
      write_byte(8'h22, 1'b0);
      repeat (16) tick();
      check("mid_tx_bit3", tx, 1'b0);
      check("mid_busy", busy, 1'b1);
      check("mid_count", count, 6'd2);
      #2;
      reset = 1'b1;
      #1;
      check("arst_tx", tx, 1'b1);
      check("arst_busy", busy, 1'b0);
      check("arst_count", count, 6'd0);
      check("arst_empty", empty, 1'b1);
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      tick();
      run_frame(8'hC3, 10'b1_1100_0011_0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: the transmit-direction counterpart of the existing receive-into-FIFO path. It accepts bytes from the system side through a 32-entry FIFO and serializes them as 8N1 frames on `tx`. It sends back-to-back frames with no idle gap while data remains queued. Baud timing comes from an internal cycle counter on the single system clock; no derived clocks are used.

## Interface
- `CLKS_PER_BIT`, 1252: system clock cycles per serial bit. Must be ≥ 2.
- `DEPTH`, 32: FIFO entries. Must be a power of 2.
- `CNT_W`, 6: width of `count`, equal to log2(DEPTH)+1.

- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `wr_en`  in  1: push `wr_data` into the FIFO.
- `wr_data`  in  8: byte to transmit.
- `full`  out  1: FIFO holds DEPTH entries.
- `empty`  out  1: FIFO holds 0 entries.
- `count`  out  CNT_W: current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1: one-cycle pulse when `wr_en` arrives while `full`.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is on the line.
- `tx_done`  out  1: one-cycle pulse at the end of each stop bit.

## Operation
- Reset values: FIFO pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `tx` 1, `busy` 0, `tx_done` 0, FSM in IDLE, baud counter 0, bit index 0. Assertion clears everything immediately, including mid-frame; `tx` returns high without completing the frame.
- FIFO storage:
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap naturally.
  - `full`, `empty` and `count` are registered and derived from `count`.
- Write: accepted when `wr_en` and not `full` at the sampling edge. A rejected write leaves the FIFO untouched and pulses `overflow`.
- Pop: the FSM pops one entry when it is in IDLE or at the end of STOP and `empty` is 0. The popped byte is latched into an 8-bit shift register.
- Same-edge write and pop: both take effect and `count` is unchanged. A write while `full` is rejected even if a pop occurs on the same edge.
- FSM states and transitions:
  - IDLE: `tx`=1. If not `empty`, pop and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] (LSB first), each bit held for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the final cycle, pulse `tx_done`. If not `empty`, pop and go to START (no idle bit); otherwise go to IDLE.
- Baud counter: 0..CLKS_PER_BIT-1. It resets to 0 on every state change and on every DATA bit advance.
- `busy` = 1 in START, DATA and STOP.

## Timing
- `tx`, `busy` and `tx_done` are registered outputs.
- Latency: a `wr_en` sampled at edge k into an empty FIFO with the FSM in IDLE:
  - `empty` falls after edge k.
  - The pop occurs at edge k+1.
  - `tx`=0 and `busy`=1 after edge k+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles from `tx` falling to the end of the stop bit.
- `tx_done` is high for the single cycle preceding the next state's first cycle.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, giving a frame period of exactly 10×CLKS_PER_BIT.
- `count` updates one edge after an accepted write or a pop. `full` and `empty` update on the same edge as `count`.
- `overflow` is asserted during the cycle after the rejected `wr_en` edge.

## Test plan
- Single byte, CLKS_PER_BIT=4: write 0xA5 at edge k.
  - Required: `tx` low from edge k+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles.
  - Required: `tx_done` pulses once, 40 cycles after `tx` fell; `busy` then falls; `count` returns to 0.
- Burst: write 0x00, 0xFF, 0x55 on consecutive edges.
  - Required: `count` peaks at 2 (the first byte is popped one edge after being written).
  - Required: three contiguous frames with no extra high bit between stop and start; 120 cycles total; 3 `tx_done` pulses.
- Full/overflow, CLKS_PER_BIT=1252: write 33 bytes with the FSM stalled mid-frame, so the first byte is popped and 32 fill the FIFO.
  - Required: `full`=1, `count`=32.
  - Required: the 34th write pulses `overflow`, and the contents are unchanged.
  - Required: the transmitted sequence matches the accepted bytes in order.
- Wrap-around: stream 70 bytes with an incrementing pattern, keeping occupancy between 1 and 31.
  - Required: all 70 bytes decoded in order by a bench UART model; `count` never exceeds 32.
- Simultaneous write and pop at a STOP end with `count`=5: required `count` stays 5 and the next frame starts immediately.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - Required: `tx`=1, `busy`=0, `count`=0, `empty`=1 asynchronously.
  - Required: after release, a new write produces a clean full frame.
